// File: rtl/adc_duty_sampler_pkg.sv
// ---------------------------------------------------------------------------
// adc_duty_sampler_pkg
//   Shared definitions for the ADC duty sampler: SPI sequencer state encoding,
//   serial frame length, and the default timing constants for the
//   100 MHz / 1 MHz SCLK / 5 ms sample-period system.
// ---------------------------------------------------------------------------
package adc_duty_sampler_pkg;

    // SPI sequencer states. A conversion walks through them in this order.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    // Bits clocked out of the ADC per conversion (MSB first).
    localparam int FRAME_BITS = 16;

    // clk cycles per SCLK half-period: 100 MHz / (2*50) = 1 MHz SCLK.
    localparam int DEF_CLK_DIV = 50;

    // clk cycles between conversion starts: 5 ms at 100 MHz.
    localparam int DEF_SAMPLE_PERIOD = 500000;

    // Bit position of the 8-bit code LSB inside the received frame.
    localparam int DEF_DATA_LSB = 4;

endpackage

// File: rtl/adc_duty_sampler_tick_gen.sv
// ---------------------------------------------------------------------------
// sample_tick_gen
//   Free-running sample-period counter. While en is high it counts
//   0..PERIOD-1 and wraps; tick is a registered one-cycle pulse issued once
//   per period. With en low the counter is held at zero, so the first tick
//   comes PERIOD cycles after en is seen high.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   en     in   counting enable; low clears the counter
//   tick   out  one-cycle pulse, once every PERIOD cycles while enabled
// ---------------------------------------------------------------------------
module sample_tick_gen #(
    parameter int PERIOD = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!en) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == LAST) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_duty_sampler.sv
// ---------------------------------------------------------------------------
// adc_duty_sampler
//   Periodically reads an 8-bit serial ADC (SPI mode 3, 16-bit MSB-first
//   frame) and presents the converted code as the duty command for the PWM
//   driver. The last good code is held between conversions; an aborted
//   conversion never disturbs it.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active low
//   en          in   sampling enable; low aborts any conversion, clears overrun
//   spi_miso    in   ADC serial data
//   spi_sclk    out  ADC serial clock, idles high (flop output)
//   spi_cs_n    out  ADC chip select, active low (flop output)
//   duty        out  8-bit duty command, updated only with duty_valid
//   duty_valid  out  one-cycle pulse on each duty update
//   busy        out  high from conversion start to end of the quiet time
//   overrun     out  sticky: a sample tick arrived while busy
// ---------------------------------------------------------------------------
module adc_duty_sampler
    import adc_duty_sampler_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int DATA_LSB      = DEF_DATA_LSB
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       spi_miso,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic [7:0] duty,
    output logic       duty_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
    localparam logic [3:0]    BIT_LAST   = 4'(FRAME_BITS - 1);

    // ------------------------------------------------------------------
    // Sample period tick
    // ------------------------------------------------------------------
    logic tick;

    sample_tick_gen #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Sequencer state and its next-state copies
    // ------------------------------------------------------------------
    state_t                state, state_nxt;
    logic [PW-1:0]         phase, phase_nxt;
    logic [3:0]            bit_cnt, bit_cnt_nxt;
    logic [FRAME_BITS-1:0] sreg, sreg_nxt;
    logic                  sclk_nxt, cs_n_nxt, busy_nxt, overrun_nxt, duty_valid_nxt;
    logic [7:0]            duty_nxt;

    logic phase_done;
    assign phase_done = (phase == PHASE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            spi_sclk   <= 1'b1;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            duty       <= '0;
            duty_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sreg       <= sreg_nxt;
            spi_sclk   <= sclk_nxt;
            spi_cs_n   <= cs_n_nxt;
            busy       <= busy_nxt;
            overrun    <= overrun_nxt;
            duty       <= duty_nxt;
            duty_valid <= duty_valid_nxt;
        end
    end

    // All outputs are computed one cycle ahead here and registered above,
    // so sclk/cs_n come straight from flops and the state transition and
    // the output change land on the same edge.
    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase;
        bit_cnt_nxt    = bit_cnt;
        sreg_nxt       = sreg;
        sclk_nxt       = spi_sclk;
        cs_n_nxt       = spi_cs_n;
        busy_nxt       = busy;
        overrun_nxt    = overrun;
        duty_nxt       = duty;
        duty_valid_nxt = 1'b0;

        if (!en) begin
            // Abort: back to idle bus levels; the partial frame is dropped
            // and duty keeps its last good value.
            state_nxt   = ST_IDLE;
            phase_nxt   = '0;
            bit_cnt_nxt = '0;
            sclk_nxt    = 1'b1;
            cs_n_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            overrun_nxt = 1'b0;
        end else begin
            // A tick is only honoured from IDLE; one arriving mid-conversion
            // or in the quiet time is dropped and flagged.
            if (tick && busy)
                overrun_nxt = 1'b1;

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state_nxt = ST_SETUP;
                        phase_nxt = '0;
                        cs_n_nxt  = 1'b0;
                        busy_nxt  = 1'b1;
                        sclk_nxt  = 1'b1;
                    end
                end

                // cs_n low, sclk high for one half-period before the first fall.
                ST_SETUP: begin
                    if (phase_done) begin
                        state_nxt   = ST_SHIFT;
                        phase_nxt   = '0;
                        bit_cnt_nxt = '0;
                        sclk_nxt    = 1'b0;
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end

                // Each bit: low half-period, then high half-period. Data is
                // captured on the edge that raises sclk, after the ADC has
                // had a full half-period to drive it.
                ST_SHIFT: begin
                    if (!phase_done) begin
                        phase_nxt = phase + 1'b1;
                    end else begin
                        phase_nxt = '0;
                        if (!spi_sclk) begin
                            sclk_nxt = 1'b1;
                            sreg_nxt = {sreg[FRAME_BITS-2:0], spi_miso};
                        end else if (bit_cnt == BIT_LAST) begin
                            // End of the 16th high phase: frame complete.
                            state_nxt      = ST_QUIET;
                            cs_n_nxt       = 1'b1;
                            duty_nxt       = sreg[DATA_LSB+7:DATA_LSB];
                            duty_valid_nxt = 1'b1;
                        end else begin
                            sclk_nxt    = 1'b0;
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end

                // ADC quiet time before another conversion may start.
                ST_QUIET: begin
                    if (phase_done) begin
                        state_nxt = ST_IDLE;
                        phase_nxt = '0;
                        busy_nxt  = 1'b0;
                    end else begin
                        phase_nxt = phase + 1'b1;
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                    sclk_nxt  = 1'b1;
                    cs_n_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_duty_sampler.sv
module tb_adc_duty_sampler;

    localparam int CD  = 50;
    localparam int SP0 = 2000;   // shortened period for the main instance
    localparam int SP1 = 1000;   // shorter than the busy time: forces overrun

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: normal operation
    logic       en0 = 1'b0, miso0 = 1'b0;
    logic       sclk0, cs0, dv0, busy0, ovr0;
    logic [7:0] duty0;
    // DUT 1: overrun scenario
    logic       en1 = 1'b0, miso1 = 1'b0;
    logic       sclk1, cs1, dv1, busy1, ovr1;
    logic [7:0] duty1;

    adc_duty_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP0), .DATA_LSB(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .spi_miso(miso0),
        .spi_sclk(sclk0), .spi_cs_n(cs0), .duty(duty0), .duty_valid(dv0),
        .busy(busy0), .overrun(ovr0));

    adc_duty_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP1), .DATA_LSB(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .spi_miso(miso1),
        .spi_sclk(sclk1), .spi_cs_n(cs1), .duty(duty1), .duty_valid(dv1),
        .busy(busy1), .overrun(ovr1));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: k-th sclk fall after cs_n fall drives frame[15-k].
    logic [15:0] frame0 = 16'h0000, frame1 = 16'h0000;
    int idx0 = 15, idx1 = 15;
    always @(negedge cs0) idx0 = 15;
    always @(negedge sclk0) if (!cs0 && idx0 >= 0) begin miso0 = frame0[idx0]; idx0--; end
    always @(negedge cs1) idx1 = 15;
    always @(negedge sclk1) if (!cs1 && idx1 >= 0) begin miso1 = frame1[idx1]; idx1--; end

    // DUT 0 monitor (sampled on the falling clk edge)
    logic psclk0 = 1'b1, pcs0 = 1'b1, pbusy0 = 1'b0;
    logic [7:0] pduty0 = 8'h00;
    int cs_fall0 = 0, rises0 = 0, last_edge0 = 0, dv_cyc0 = 0, dv_count0 = 0;
    int tviol0 = 0, dstab0 = 0, busy_rise0 = 0, busy_len0 = 0;
    bit first_fall0 = 1'b0;
    always @(negedge clk) begin
        if (pcs0 && !cs0) begin cs_fall0 = cyc; rises0 = 0; first_fall0 = 1'b1; end
        if (!psclk0 && sclk0 && !cs0) rises0++;
        if (sclk0 != psclk0) begin
            if (cs0 && pcs0) tviol0++;
            else if (!cs0 && !pcs0) begin
                if (first_fall0) begin
                    if (cyc - cs_fall0 < CD) tviol0++;
                    first_fall0 = 1'b0;
                end else if (cyc - last_edge0 != CD) tviol0++;
                last_edge0 = cyc;
            end
        end
        if (dv0) begin dv_cyc0 = cyc; dv_count0++; end
        if (duty0 != pduty0 && !dv0) dstab0++;
        if (busy0 && !pbusy0) busy_rise0 = cyc;
        if (!busy0 && pbusy0) busy_len0 = cyc - busy_rise0;
        psclk0 = sclk0; pcs0 = cs0; pduty0 = duty0; pbusy0 = busy0;
    end

    // DUT 1 monitor: cs_n high gap between consecutive frames
    logic pcs1 = 1'b1;
    bit seen1 = 1'b0;
    int hi1 = 0, min_gap1 = 1000000, dv_count1 = 0;
    always @(negedge clk) begin
        if (cs1) hi1++;
        if (pcs1 && !cs1) begin
            if (seen1 && hi1 < min_gap1) min_gap1 = hi1;
            hi1 = 0;
        end
        if (!pcs1 && cs1) seen1 = 1'b1;
        if (dv1) dv_count1++;
        pcs1 = cs1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv0(input int maxc, output bit ok);
        int start;
        start = dv_count0;
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk); #1;
            if (dv_count0 != start) ok = 1'b1;
        end
    endtask

    task automatic wait_rises0(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk); #1;
            if (rises0 == n && !cs0) ok = 1'b1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int en_cyc, prev_dv, cnt_hold;
        logic [7:0] codes [3];
        codes[0] = 8'h00; codes[1] = 8'hFF; codes[2] = 8'h80;

        // ---- reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs0, 1'b1);
        check("rst_sclk", sclk0, 1'b1);
        check("rst_duty", duty0, 8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_dv", dv0, 1'b0);
        check("rst_overrun", ovr0, 1'b0);
        rst_n = 1'b1;

        // ---- single conversion, code 0xA5
        frame0 = 16'b0000_1010_0101_0000;
        @(posedge clk); #1;
        en0 = 1'b1; en_cyc = cyc;
        wait_dv0(SP0 + 2000, ok);
        check("conv_dv_seen", ok, 1'b1);
        check("first_tick_cs_fall", cs_fall0 - en_cyc, SP0 + 1);
        check("tick_to_dv", dv_cyc0 - cs_fall0 + 1, 33 * CD + 1);
        check("conv_duty", duty0, 8'hA5);
        check("conv_rises", rises0, 16);
        check("conv_cs_high_at_dv", cs0, 1'b1);
        @(negedge clk); #1;
        check("dv_one_cycle", dv0, 1'b0);
        repeat (CD + 5) @(negedge clk);
        #1;
        check("busy_len", busy_len0, 34 * CD);
        check("busy_low_after", busy0, 1'b0);

        // ---- abort after 5th sclk rise
        frame0 = 16'h03C0;
        wait_rises0(5, SP0 + 100, ok);
        check("abort_reached_bit5", ok, 1'b1);
        en0 = 1'b0;
        cnt_hold = dv_count0;
        @(negedge clk); #1;
        check("abort_cs_n", cs0, 1'b1);
        check("abort_sclk", sclk0, 1'b1);
        check("abort_busy", busy0, 1'b0);
        repeat (200) @(negedge clk);
        #1;
        check("abort_no_dv", dv_count0, cnt_hold);
        check("abort_duty_held", duty0, 8'hA5);

        // ---- re-enable: fresh period, normal conversion
        frame0 = 16'h05A0;
        @(posedge clk); #1;
        en0 = 1'b1; en_cyc = cyc;
        wait_dv0(SP0 + 2000, ok);
        check("reen_dv_seen", ok, 1'b1);
        check("reen_first_tick", cs_fall0 - en_cyc, SP0 + 1);
        check("reen_duty", duty0, 8'h5A);

        // ---- three periods: 0x00, 0xFF, 0x80
        for (int i = 0; i < 3; i++) begin
            prev_dv = dv_cyc0;
            frame0 = {4'h0, codes[i], 4'h0};
            wait_dv0(SP0 + 200, ok);
            check("period_dv_seen", ok, 1'b1);
            check("period_spacing", dv_cyc0 - prev_dv, SP0);
            check("period_duty", duty0, codes[i]);
        end

        // ---- overrun on DUT 1
        frame1 = 16'h0C30;
        @(posedge clk); #1;
        en1 = 1'b1; en_cyc = cyc;
        wait_until(en_cyc + 1500);
        check("ovr_before_2nd_tick", ovr1, 1'b0);
        check("ovr_busy_mid", busy1, 1'b1);
        wait_until(en_cyc + 2100);
        check("ovr_after_2nd_tick", ovr1, 1'b1);
        wait_until(en_cyc + 5000);
        check("ovr_conversions", dv_count1, 2);
        check("ovr_duty", duty1, 8'hC3);
        check("ovr_gap_min", (min_gap1 >= CD && min_gap1 < 10000), 1'b1);
        en1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("ovr_cleared_by_en", ovr1, 1'b0);
        check("ovr_cs_idle", cs1, 1'b1);

        // ---- accumulated timing / stability checks on DUT 0
        check("timing_violations", tviol0, 0);
        check("duty_stable", dstab0, 0);

        // ---- asynchronous reset mid-SHIFT
        wait_rises0(3, SP0 + 100, ok);
        check("rst_mid_reached", ok, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cs_n", cs0, 1'b1);
        check("arst_sclk", sclk0, 1'b1);
        check("arst_duty", duty0, 8'h00);
        check("arst_busy", busy0, 1'b0);
        check("arst_overrun", ovr0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
